serial_sub_ctrl: RTL and testbench

- Bit-serial N-bit subtractor controller: computes diff = a - b one bit per clock, LSB first, by sequencing a single full-subtractor cell built from two half subtractors plus a registered borrow.
- Accepts operands through a start/busy/done handshake.
- Sits between the board's operand registers (switches/UART) and the display/LED output logic.

---
 rtl/sub_pkg.sv | 12 +
 rtl/full_sub_cell.sv | 25 ++
 rtl/serial_sub_ctrl.sv | 106 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and default width for the serial subtractor
package sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - combinational full subtractor built from two half subtractors
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  // first half subtractor: a - b
  assign w_d1 = a ^ b;
  assign w_b1 = ~a & b;

  // second half subtractor: (a - b) - bin
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;

  // a borrow from either stage propagates to the next bit
  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial LSB-first subtractor with start/busy/done handshake
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // holds the upper WIDTH-1 result bits; the newest bit enters at the top
  logic [WIDTH-2:0] r_res_sh;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_d;
  logic             w_br;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  full_sub_cell u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br)
  );

  assign w_res_next = {w_d, r_res_sh};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // control FSM plus the operand/result shift datapath, all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res_sh     <= '0;
      r_br         <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= ST_RUN;
            r_a_sh   <= a_in;
            r_b_sh   <= b_in;
            r_res_sh <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_res_sh <= w_res_next[WIDTH-1:1];
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_br     <= w_br;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
            r_diff       <= w_res_next;
            r_borrow_out <= w_br;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH 8 and 16
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [2];
  logic [31:0] a_v   [2];
  logic [31:0] b_v   [2];

  logic        busy8, done8, br8;
  logic [7:0]  diff8;
  logic        busy16, done16, br16;
  logic [15:0] diff16;

  logic        o_busy [2];
  logic        o_done [2];
  logic        o_br   [2];
  logic [31:0] o_diff [2];

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start[0]),
    .a_in       (a_v[0][7:0]),
    .b_in       (b_v[0][7:0]),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (br8)
  );

  serial_sub_ctrl #(.WIDTH(16)) u_dut16 (
    .clk        (clk),
    .rst        (rst),
    .start      (start[1]),
    .a_in       (a_v[1][15:0]),
    .b_in       (b_v[1][15:0]),
    .busy       (busy16),
    .done       (done16),
    .diff       (diff16),
    .borrow_out (br16)
  );

  assign o_busy[0] = busy8;
  assign o_done[0] = done8;
  assign o_br[0]   = br8;
  assign o_diff[0] = {24'b0, diff8};
  assign o_busy[1] = busy16;
  assign o_done[1] = done16;
  assign o_br[1]   = br16;
  assign o_diff[1] = {16'b0, diff16};

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  function automatic int wid(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic logic [31:0] mask(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: an accepted request yields (a-b) mod 2^W and (a<b)
  // after W+1 edges; the unit is unavailable for W+2 cycles in total.
  int          m_age  [2];
  logic [31:0] m_pend [2];
  logic        m_pbr  [2];
  logic        e_busy [2];
  logic        e_done [2];
  logic [31:0] e_diff [2];
  logic        e_br   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_age[k] = 0; m_pend[k] = 0; m_pbr[k] = 0;
      e_busy[k] = 0; e_done[k] = 0; e_diff[k] = 0; e_br[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_age[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_diff[k] = 0; e_br[k] = 0;
        end else if (m_age[k] == 0) begin
          e_done[k] = 0;
          if (start[k]) begin
            m_age[k]  = 1;
            m_pend[k] = (a_v[k] - b_v[k]) & mask(k);
            m_pbr[k]  = (a_v[k] & mask(k)) < (b_v[k] & mask(k));
            e_busy[k] = 1;
          end
        end else if (m_age[k] < wid(k)) begin
          m_age[k]++;
        end else if (m_age[k] == wid(k)) begin
          m_age[k]++;
          e_done[k] = 1;
          e_diff[k] = m_pend[k];
          e_br[k]   = m_pbr[k];
        end else begin
          m_age[k]  = 0;
          e_done[k] = 0;
          e_busy[k] = 0;
        end
      end
    end
  end

  // every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("model_busy%0d", wid(k)), {31'b0, o_busy[k]}, {31'b0, e_busy[k]});
          chk($sformatf("model_done%0d", wid(k)), {31'b0, o_done[k]}, {31'b0, e_done[k]});
          chk($sformatf("model_diff%0d", wid(k)), o_diff[k], e_diff[k]);
          chk($sformatf("model_borrow%0d", wid(k)), {31'b0, o_br[k]}, {31'b0, e_br[k]});
        end
      end
    end
  end

  // one request on instance k; latency counts edges from the accepting edge to the
  // edge that raises done, inclusive
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_br, input string tag);
    int n;
    @(negedge clk);
    start[k] = 1'b1; a_v[k] = a; b_v[k] = b;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start[k] = 1'b0;
    while (!o_done[k] && n < 100) begin
      a_v[k] = $urandom; b_v[k] = $urandom;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, wid(k) + 1);
    chk({tag, "_diff"}, o_diff[k], exp_d);
    chk({tag, "_borrow"}, {31'b0, o_br[k]}, {31'b0, exp_br});
    @(negedge clk);
    chk({tag, "_done_drop"}, {31'b0, o_done[k]}, 32'd0);
  endtask

  task automatic wait_done(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done[k] && n < 100);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy8}, 32'd0);
    chk("reset_done", {31'b0, done8}, 32'd0);
    chk("reset_diff", {24'b0, diff8}, 32'h00);
    chk("reset_borrow", {31'b0, br8}, 32'd0);

    run_op(0, 32'd9,  32'd5,  32'd4,   1'b0, "basic_9_5");
    run_op(0, 32'd5,  32'd9,  32'hFC,  1'b1, "wrap_5_9");
    run_op(0, 32'h00, 32'h01, 32'hFF,  1'b1, "wrap_0_1");
    run_op(0, 32'hFF, 32'hFF, 32'h00,  1'b0, "equal_ff");

    // second request while busy is dropped
    @(negedge clk);
    start[0] = 1'b1; a_v[0] = 32'd20; b_v[0] = 32'd3;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    start[0] = 1'b1; a_v[0] = 32'd1; b_v[0] = 32'd2;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, n);
    chk("ignored_start_diff", o_diff[0], 32'd17);
    chk("ignored_start_borrow", {31'b0, o_br[0]}, 32'd0);
    repeat (3) @(negedge clk);

    // start held high: back-to-back operations every WIDTH+2 cycles
    start[0] = 1'b1; a_v[0] = 32'd50; b_v[0] = 32'd8;
    wait_done(0, n);
    chk("held_first_diff", o_diff[0], 32'd42);
    wait_done(0, n);
    chk("held_period_1", n, 32'd10);
    wait_done(0, n);
    chk("held_period_2", n, 32'd10);
    start[0] = 1'b0;
    repeat (12) @(negedge clk);

    // reset on the fourth RUN cycle discards the operation
    start[0] = 1'b1; a_v[0] = 32'hA5; b_v[0] = 32'h5A;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy8}, 32'd0);
    chk("midrst_diff", {24'b0, diff8}, 32'd0);
    chk("midrst_borrow", {31'b0, br8}, 32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) n++;
    end
    chk("midrst_no_done", n, 32'd0);
    run_op(0, 32'd7, 32'd7, 32'd0, 1'b0, "after_rst_7_7");

    run_op(1, 32'h1234, 32'h0235, 32'h0FFF, 1'b0, "w16_1234_0235");
    run_op(1, 32'h0001, 32'hFFFF, 32'h0002, 1'b1, "w16_1_ffff");

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom & mask(k);
        rb = $urandom & mask(k);
        run_op(k, ra, rb, (ra - rb) & mask(k), ra < rb, $sformatf("rand%0d", wid(k)));
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
